// File: rtl/seq_detect_param.sv
// seq_detect_param
// Serial pattern detector for a 1-bit stream qualified by data_valid.
// The PAT_W-bit pattern can be reloaded at run time. Detection can be
// overlapping or non-overlapping. A registered one-cycle flag marks each
// match, and a saturating counter tallies the matches.
module seq_detect_param #(
   parameter int                 PAT_W    = 5,
   parameter logic [PAT_W-1:0]   PAT_INIT = 5'b10111,
   parameter int                 CNT_W    = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               data_valid,
   input  logic               data,
   input  logic               overlap,
   input  logic               pat_load,
   input  logic [PAT_W-1:0]   pat_in,
   input  logic               cnt_clr,
   output logic               flag,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               armed
);

   localparam int                FILL_W    = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

   // One-hot style encoding leaves 2'b00 and 2'b11 unused; both recover to FILL.
   typedef enum logic [1:0] {
      FILL = 2'b01,
      HUNT = 2'b10
   } state_t;

   state_t              state_q, state_d;
   logic [PAT_W-1:0]    pat_q,   pat_d;
   logic [PAT_W-1:0]    hist_q,  hist_d;
   logic [FILL_W-1:0]   fill_q,  fill_d;
   logic                flag_q,  flag_d;
   logic [CNT_W-1:0]    cnt_q,   cnt_d;
   logic [PAT_W-1:0]    window;
   logic                hit;

   // The newest PAT_W bits once the current bit is appended.
   assign window = {hist_q[PAT_W-2:0], data};

   // Next-state, pattern, history, flag and counter logic.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d = state_q;
      pat_d   = pat_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      hit     = 1'b0;

      if (pat_load) begin
         // A new pattern restarts the fill. Any data bit on this edge is dropped.
         pat_d   = pat_in;
         fill_d  = '0;
         state_d = FILL;
      end else begin
         unique case (state_q)
            FILL: begin
               if (data_valid) begin
                  hist_d = window;
                  fill_d = fill_q + FILL_W'(1);
                  if (fill_d == FILL_LAST) state_d = HUNT;
               end
            end
            HUNT: begin
               if (data_valid) begin
                  hist_d = window;
                  if (window == pat_q) begin
                     hit = 1'b1;
                     if (!overlap) begin
                        // A non-overlapping match needs PAT_W fresh bits for the next hit.
                        fill_d  = '0;
                        state_d = FILL;
                     end
                  end
               end
            end
            default: begin
               fill_d  = '0;
               state_d = FILL;
            end
         endcase
      end

      flag_d = hit;

      // A clear takes priority, but a match on the same edge still counts once.
      cnt_d = cnt_q;
      if (cnt_clr)                  cnt_d = hit ? CNT_W'(1) : '0;
      else if (hit && cnt_q != '1)  cnt_d = cnt_q + CNT_W'(1);
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FILL;
         pat_q   <= PAT_INIT;
         hist_q  <= '0;
         fill_q  <= '0;
         flag_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         pat_q   <= pat_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         flag_q  <= flag_d;
         cnt_q   <= cnt_d;
      end
   end

   assign flag      = flag_q;
   assign match_cnt = cnt_q;
   assign armed     = (state_q == HUNT);

endmodule
